// File: rtl/sfp_pkg.sv
// Shared definitions for the sfp special-function unit, its job sequencer and benches.
package sfp_pkg;

  localparam int unsigned BW      = 8;
  localparam int unsigned PSUM_BW = 16;
  localparam int unsigned LEN_BW  = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    ACC  = 3'd2,
    RELU = 3'd3,
    DONE = 3'd4
  } sfp_state_t;

endpackage

// File: rtl/sfp_ctrl.sv
// Job sequencer for the sfp unit: clear, accumulate len accepted samples, optional ReLU, done pulse.
module sfp_ctrl
  import sfp_pkg::*;
#(
  parameter int unsigned len_bw  = LEN_BW,
  parameter int unsigned psum_bw = PSUM_BW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [len_bw-1:0]  len,
  input  logic [psum_bw-1:0] thres_cfg,
  input  logic               relu_en,
  input  logic               abort,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               sfp_clr,
  output logic               sfp_acc,
  output logic               sfp_relu,
  output logic [psum_bw-1:0] sfp_thres,
  output logic               busy,
  output logic               done
);

  sfp_state_t         r_state;
  sfp_state_t         w_next;
  logic [len_bw-1:0]  r_count;
  logic [len_bw-1:0]  r_len;
  logic               r_relu_en;
  logic [psum_bw-1:0] r_thres;
  logic               w_start_ok;
  logic               w_last;

  assign w_start_ok = (r_state == IDLE) && start;
  // Terminal compare against len-1 keeps the counter from ever wrapping.
  assign w_last     = in_valid && (r_count == (r_len - len_bw'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (len != '0) ? CLR : DONE;
        end
      end
      CLR:  w_next = ACC;
      ACC: begin
        if (w_last) begin
          w_next = r_relu_en ? RELU : DONE;
        end
      end
      RELU: w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (abort && (r_state != IDLE)) begin
      w_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len     <= '0;
      r_relu_en <= 1'b0;
      r_thres   <= '0;
      r_count   <= '0;
    end else begin
      if (w_start_ok) begin
        r_len     <= len;
        r_relu_en <= relu_en;
        r_thres   <= thres_cfg;
      end
      if (r_state == CLR) begin
        r_count <= '0;
      end else if ((r_state == ACC) && in_valid) begin
        r_count <= r_count + len_bw'(1);
      end
    end
  end

  always_comb begin
    in_ready  = (r_state == ACC);
    sfp_clr   = (r_state == CLR);
    sfp_acc   = (r_state == ACC) && in_valid;
    sfp_relu  = (r_state == RELU);
    done      = (r_state == DONE);
    busy      = (r_state != IDLE);
    sfp_thres = r_thres;
  end

endmodule

// File: tb/tb_sfp_ctrl.sv
// Directed bench for sfp_ctrl: per-cycle vector table plus a hand-written async reset sequence.
module tb_sfp_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic [15:0] thres_cfg;
  logic        relu_en;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic        sfp_clr;
  logic        sfp_acc;
  logic        sfp_relu;
  logic [15:0] sfp_thres;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  // expected flags packed as {in_ready, sfp_clr, sfp_acc, sfp_relu, busy, done}
  localparam logic [5:0] E_IDLE = 6'b000000;
  localparam logic [5:0] E_CLR  = 6'b010010;
  localparam logic [5:0] E_ACC1 = 6'b101010;
  localparam logic [5:0] E_ACC0 = 6'b100010;
  localparam logic [5:0] E_RELU = 6'b000110;
  localparam logic [5:0] E_DONE = 6'b000011;

  typedef struct {
    string       name;
    logic        start;
    logic [7:0]  len;
    logic [15:0] thres;
    logic        relu_en;
    logic        abort;
    logic        in_valid;
    logic [5:0]  e_flags;
    logic [15:0] e_thres;
  } vec_t;

  vec_t  vq[$];
  string sect;

  sfp_ctrl #(.len_bw(8), .psum_bw(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .thres_cfg (thres_cfg),
    .relu_en   (relu_en),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sfp_clr   (sfp_clr),
    .sfp_acc   (sfp_acc),
    .sfp_relu  (sfp_relu),
    .sfp_thres (sfp_thres),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic v(input logic st, input logic [7:0] ln, input logic [15:0] th, input logic re,
                   input logic ab, input logic iv, input logic [5:0] ef, input logic [15:0] et);
    vec_t x;
    x.name = $sformatf("%s[%0d]", sect, vq.size());
    x.start = st; x.len = ln; x.thres = th; x.relu_en = re;
    x.abort = ab; x.in_valid = iv; x.e_flags = ef; x.e_thres = et;
    vq.push_back(x);
  endtask

  task automatic idle(input logic iv, input logic [15:0] et);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, iv, E_IDLE, et);
  endtask

  task automatic run_vectors();
    foreach (vq[i]) begin
      @(negedge clk);
      start = vq[i].start; len = vq[i].len; thres_cfg = vq[i].thres;
      relu_en = vq[i].relu_en; abort = vq[i].abort; in_valid = vq[i].in_valid;
      #1;
      chk({vq[i].name, " flags"}, {26'd0, in_ready, sfp_clr, sfp_acc, sfp_relu, busy, done},
          {26'd0, vq[i].e_flags});
      chk({vq[i].name, " thres"}, {16'd0, sfp_thres}, {16'd0, vq[i].e_thres});
    end
    vq.delete();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; len = '0; thres_cfg = '0;
    relu_en = 1'b0; abort = 1'b0; in_valid = 1'b0;
    #12;
    chk("reset flags", {26'd0, in_ready, sfp_clr, sfp_acc, sfp_relu, busy, done}, 32'd0);
    chk("reset thres", {16'd0, sfp_thres}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // basic: len=10, relu on
    sect = "basic";
    v(1'b1, 8'd10, 16'd64, 1'b1, 1'b0, 1'b1, E_IDLE, 16'd0);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_CLR, 16'd64);
    for (int i = 0; i < 10; i++) v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_ACC1, 16'd64);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_RELU, 16'd64);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_DONE, 16'd64);
    idle(1'b1, 16'd64);

    // stall: len=4, valid 1,0,0,1,1,0,1
    sect = "stall";
    v(1'b1, 8'd4, 16'd5, 1'b1, 1'b0, 1'b0, E_IDLE, 16'd64);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, E_CLR, 16'd5);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_ACC1, 16'd5);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, E_ACC0, 16'd5);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, E_ACC0, 16'd5);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_ACC1, 16'd5);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_ACC1, 16'd5);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, E_ACC0, 16'd5);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_ACC1, 16'd5);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_RELU, 16'd5);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_DONE, 16'd5);
    idle(1'b0, 16'd5);

    // len=0: straight to done; a start during done is ignored
    sect = "zero";
    v(1'b1, 8'd0, 16'd7, 1'b1, 1'b0, 1'b1, E_IDLE, 16'd5);
    v(1'b1, 8'd3, 16'd8, 1'b0, 1'b0, 1'b1, E_DONE, 16'd7);
    idle(1'b1, 16'd7);
    idle(1'b0, 16'd7);

    // len=3 without relu
    sect = "norelu";
    v(1'b1, 8'd3, 16'd9, 1'b0, 1'b0, 1'b1, E_IDLE, 16'd7);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_CLR, 16'd9);
    for (int i = 0; i < 3; i++) v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_ACC1, 16'd9);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_DONE, 16'd9);
    idle(1'b0, 16'd9);

    // abort in ACC after 3 accepts; then start+abort in IDLE (start wins), len=2
    sect = "abort";
    v(1'b1, 8'd8, 16'd11, 1'b1, 1'b0, 1'b1, E_IDLE, 16'd9);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_CLR, 16'd11);
    for (int i = 0; i < 3; i++) v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_ACC1, 16'd11);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b1, 1'b1, E_ACC1, 16'd11);
    v(1'b1, 8'd2, 16'd12, 1'b0, 1'b1, 1'b1, E_IDLE, 16'd11);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_CLR, 16'd12);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_ACC1, 16'd12);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_ACC1, 16'd12);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_DONE, 16'd12);
    idle(1'b0, 16'd12);

    // abort during CLR
    sect = "abortclr";
    v(1'b1, 8'd5, 16'd13, 1'b1, 1'b0, 1'b0, E_IDLE, 16'd12);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b1, 1'b1, E_CLR, 16'd13);
    idle(1'b1, 16'd13);

    // start while busy is ignored: exactly 6 acc strobes, thres unchanged
    sect = "busystart";
    v(1'b1, 8'd6, 16'd20, 1'b0, 1'b0, 1'b1, E_IDLE, 16'd13);
    v(1'b1, 8'd5, 16'd99, 1'b1, 1'b0, 1'b1, E_CLR, 16'd20);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_ACC1, 16'd20);
    v(1'b1, 8'd5, 16'd99, 1'b1, 1'b0, 1'b1, E_ACC1, 16'd20);
    for (int i = 0; i < 4; i++) v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_ACC1, 16'd20);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_DONE, 16'd20);
    idle(1'b0, 16'd20);

    // run into ACC for the async reset sequence
    sect = "prereset";
    v(1'b1, 8'd6, 16'd30, 1'b1, 1'b0, 1'b1, E_IDLE, 16'd20);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_CLR, 16'd30);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_ACC1, 16'd30);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_ACC1, 16'd30);
    run_vectors();

    // async reset between clock edges while in ACC, in_valid still high
    @(posedge clk);
    #2;
    chk("pre-reset acc", {31'd0, sfp_acc}, 32'd1);
    reset = 1'b0;
    #1;
    chk("async busy", {31'd0, busy}, 32'd0);
    chk("async acc", {31'd0, sfp_acc}, 32'd0);
    chk("async ready", {31'd0, in_ready}, 32'd0);
    chk("async thres", {16'd0, sfp_thres}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;

    sect = "postreset";
    idle(1'b1, 16'd0);
    v(1'b1, 8'd1, 16'd40, 1'b0, 1'b0, 1'b1, E_IDLE, 16'd0);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_CLR, 16'd40);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_ACC1, 16'd40);
    v(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, E_DONE, 16'd40);
    idle(1'b0, 16'd40);
    run_vectors();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sfp_ctrl.md
Name: sfp_ctrl

Overview:
- Job sequencer for the sfp accumulate/ReLU special-function unit.
- Accepts a job command: sample count, threshold, ReLU enable.
- Clears the sfp accumulator, then drives acc for exactly len accepted input samples, stalling whenever the sample source is not valid.
- Issues an optional one-cycle relu, then pulses done; sits between the psum/data feeder and the sfp instance.

Parameters:
- len_bw, 8, width of job length and sample counter (max job = 2^len_bw-1 samples)
- psum_bw, 16, width of sfp threshold / psum path

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low (0 = reset asserted); one clock, reset is asynchronous and active-low
- start  input  1  job request, sampled only in IDLE
- len  input  len_bw  number of samples to accumulate, sampled with start
- thres_cfg  input  psum_bw  threshold for the job, sampled with start
- relu_en  input  1  apply ReLU at end of job, sampled with start
- abort  input  1  cancel current job
- in_valid  input  1  feeder has a sample on sfp in this cycle
- in_ready  output  1  controller accepts a sample this cycle
- sfp_clr  output  1  one-cycle accumulator clear to sfp
- sfp_acc  output  1  sfp accumulate strobe
- sfp_relu  output  1  sfp ReLU strobe
- sfp_thres  output  psum_bw  threshold held to sfp
- busy  output  1  job in progress (state != IDLE)
- done  output  1  one-cycle job-complete pulse

Behaviour:
- States: IDLE, CLR, ACC, RELU, DONE. Registered state; outputs decoded from state (sfp_acc also uses in_valid).
- Reset (reset=0, async): state=IDLE, count=0, latched len/relu_en=0, sfp_thres=0; all 1-bit outputs 0.
- IDLE: start=1 latches len, thres_cfg->sfp_thres, relu_en.
  - len!=0 -> CLR.
  - len==0 -> DONE directly; no clr/acc/relu issued.
- CLR: sfp_clr=1 for exactly one cycle; count<=0; -> ACC.
- ACC: in_ready=1; sfp_acc = in_valid. Each cycle with in_valid=1 is an accepted sample and count increments.
  - in_valid=0: sfp_acc=0 and count holds (stall, unbounded).
  - On the accept where count==len-1: -> RELU if relu_en, else -> DONE.
- RELU: sfp_relu=1 one cycle, sfp_acc=0, in_ready=0; -> DONE.
- DONE: done=1 one cycle; -> IDLE.
- Latency with start sampled at edge k and in_valid held at 1:
  - sfp_clr high in cycle k+1.
  - sfp_acc high cycles k+2..k+1+len.
  - relu (if enabled) in cycle k+2+len.
  - done in cycle k+3+len with relu, k+2+len without.
- sfp_thres: constant from the cycle after start acceptance until the next accepted start; not cleared by done or abort.
- start while busy: ignored; no latch update.
- start and done in the same cycle: the start is ignored (state is DONE, not IDLE).
- abort=1 in any state other than IDLE: next state IDLE, done NOT pulsed. Outputs drop in the following cycle.
  - In the abort cycle itself, sfp_acc still follows in_valid in ACC, so the feeder's handshake stays consistent.
- abort in IDLE: no effect. abort and start together in IDLE: start wins.
- Counter: len_bw bits; no wrap possible since the terminal compare is against len-1 and len<=2^len_bw-1.
- Reset mid-job: immediate return to IDLE; latched configuration cleared; no done.
- in_valid outside ACC: ignored; in_ready=0.

Decomposition:
- Shared package sfp_pkg: state encoding constants (IDLE=0, CLR=1, ACC=2, RELU=3, DONE=4, 3-bit), default bw=8 / psum_bw=16 / len_bw=8 constants shared with sfp and its bench.
- No sub-module; FSM plus one counter fit in a single module.

Test Plan:
- Basic: reset, start with len=10, thres_cfg=64, relu_en=1, in_valid=1 -> sfp_clr at k+1, sfp_acc 10 cycles k+2..k+11, sfp_relu at k+12, done at k+13, sfp_thres=64 throughout, busy low after done.
- Stall: len=4, in_valid pattern 1,0,0,1,1,0,1 -> sfp_acc exactly mirrors valid; 4 accepts; done 2 cycles after the 4th accept (relu_en=1); count holds during gaps.
- Zero/no-relu: len=0 -> done at k+1, no sfp_clr/sfp_acc. len=3, relu_en=0 -> sfp_relu never asserts; done at k+5.
- Abort: len=8, abort after 3 accepts -> IDLE next cycle, no done, no relu; a new start with len=2 runs cleanly with a fresh sfp_clr.
- Start while busy: second start with len=5, thres_cfg=99 during a len=6 job -> ignored; exactly 6 acc strobes; sfp_thres stays at the first value.
- Async reset mid-ACC: drive reset=0 between clock edges -> busy, sfp_acc, in_ready drop immediately; sfp_thres=0; after release, start with len=1 -> clr, 1 acc, done.
